// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared types and helpers for the voice allocator and mixer
package synth_pkg;

  typedef enum logic {
    MIX_AVERAGE  = 1'b0,
    MIX_SATURATE = 1'b1
  } mix_mode_e;

  typedef enum logic [1:0] {
    ALLOC_IDLE   = 2'd0,
    ALLOC_DECIDE = 2'd1,
    ALLOC_COMMIT = 2'd2
  } alloc_state_e;

  typedef enum logic {
    MIX_IDLE  = 1'b0,
    MIX_ACCUM = 1'b1
  } mix_state_e;

  // Age counters saturate at num_voices-1, so log2 of the voice count is enough.
  function automatic int VOICE_AGE_W(input int num_voices);
    return (num_voices > 2) ? $clog2(num_voices) : 1;
  endfunction

  // Clamp a signed value into the range of a signed field of the given width.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] value,
                                                   input int width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (value > max_v) return max_v;
    if (value < min_v) return min_v;
    return value;
  endfunction

endpackage

// File: rtl/voice_mix_accum.sv
// rtl/voice_mix_accum.sv - sequential per-voice accumulator with average or saturating output
module voice_mix_accum
  import synth_pkg::*;
#(
  parameter int NUM_VOICES   = 4,
  parameter int SAMPLE_WIDTH = 16,
  parameter int MIX_MODE     = 0
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic                               sample_tick_in,
  input  logic [NUM_VOICES-1:0]              voice_on_in,
  input  logic [NUM_VOICES*SAMPLE_WIDTH-1:0] samples_in,
  output logic [SAMPLE_WIDTH-1:0]            stream_out,
  output logic                               stream_valid_out
);

  localparam int LOG2_N = $clog2(NUM_VOICES);
  localparam int ACC_W  = SAMPLE_WIDTH + LOG2_N;
  localparam logic [LOG2_N-1:0] LAST_IDX = LOG2_N'(NUM_VOICES - 1);
  localparam mix_mode_e MODE = (MIX_MODE == 1) ? MIX_SATURATE : MIX_AVERAGE;

  mix_state_e               state_q, state_d;
  logic [LOG2_N-1:0]        idx_q;
  logic [NUM_VOICES-1:0]    snap_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic                     done_q;
  logic                     start_mix;
  logic                     add_en;
  logic                     last_add;
  logic [SAMPLE_WIDTH-1:0]  cur_sample;
  logic signed [ACC_W-1:0]  cur_ext;
  logic [SAMPLE_WIDTH-1:0]  scaled;

  // Mixer state register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= MIX_IDLE;
    else         state_q <= state_d;
  end

  // Mixer next state: a tick starts a pass, the pass ends after the last voice slot.
  always_comb begin
    state_d   = state_q;
    start_mix = 1'b0;
    add_en    = 1'b0;
    last_add  = 1'b0;
    case (state_q)
      MIX_IDLE: begin
        if (sample_tick_in) begin
          start_mix = 1'b1;
          state_d   = MIX_ACCUM;
        end
      end
      MIX_ACCUM: begin
        add_en = 1'b1;
        if (idx_q == LAST_IDX) begin
          last_add = 1'b1;
          state_d  = MIX_IDLE;
        end
      end
      default: state_d = MIX_IDLE;
    endcase
  end

  // Current voice sample, sign-extended, and the scaled form of the finished sum.
  always_comb begin
    cur_sample = samples_in[idx_q*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    cur_ext    = {{LOG2_N{cur_sample[SAMPLE_WIDTH-1]}}, cur_sample};
    if (MODE == MIX_SATURATE)
      scaled = SAMPLE_WIDTH'(sat_clamp({{(64-ACC_W){acc_q[ACC_W-1]}}, acc_q}, SAMPLE_WIDTH));
    else
      scaled = SAMPLE_WIDTH'(acc_q >>> LOG2_N);
  end

  // Snapshot, accumulate one voice per cycle, then publish the result one cycle later.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      idx_q            <= '0;
      snap_q           <= '0;
      acc_q            <= '0;
      done_q           <= 1'b0;
      stream_out       <= '0;
      stream_valid_out <= 1'b0;
    end else begin
      stream_valid_out <= 1'b0;
      done_q           <= last_add;
      if (start_mix) begin
        snap_q <= voice_on_in;
        acc_q  <= '0;
        idx_q  <= '0;
      end
      if (add_en) begin
        if (snap_q[idx_q]) acc_q <= acc_q + cur_ext;
        idx_q <= idx_q + 1'b1;
      end
      if (done_q) begin
        stream_out       <= scaled;
        stream_valid_out <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/poly_voice_mixer.sv
// rtl/poly_voice_mixer.sv - polyphonic note allocator with oldest-voice stealing and output mixer
module poly_voice_mixer
  import synth_pkg::*;
#(
  parameter int NUM_VOICES   = 4,
  parameter int SAMPLE_WIDTH = 16,
  parameter int RATE_WIDTH   = 24,
  parameter int MIX_MODE     = 0
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic                               valid_in,
  output logic                               ready_out,
  input  logic                               is_note_on_in,
  input  logic [RATE_WIDTH-1:0]              rate_in,
  output logic [NUM_VOICES-1:0]              is_on_out,
  output logic [NUM_VOICES*RATE_WIDTH-1:0]   rate_out,
  output logic [NUM_VOICES-1:0]              retrig_out,
  output logic                               steal_out,
  output logic                               drop_out,
  input  logic                               sample_tick_in,
  input  logic [NUM_VOICES*SAMPLE_WIDTH-1:0] samples_in,
  output logic [SAMPLE_WIDTH-1:0]            stream_out,
  output logic                               stream_valid_out
);

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam int AGE_W = VOICE_AGE_W(NUM_VOICES);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(NUM_VOICES - 1);

  alloc_state_e          state_q, state_d;
  logic                  ev_on_q;
  logic [RATE_WIDTH-1:0] ev_rate_q;
  logic [NUM_VOICES-1:0] on_q;
  logic [RATE_WIDTH-1:0] rate_q [NUM_VOICES];
  logic [AGE_W-1:0]      age_q  [NUM_VOICES];

  logic [NUM_VOICES-1:0] match_vec;
  logic                  any_match;
  logic                  any_free;
  logic [IDX_W-1:0]      match_idx;
  logic [IDX_W-1:0]      free_idx;
  logic [IDX_W-1:0]      oldest_idx;
  logic [AGE_W-1:0]      best_age;

  logic [IDX_W-1:0]      tgt_q;
  logic                  steal_dec_q;
  logic [NUM_VOICES-1:0] off_mask_q;

  // Allocator state register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= ALLOC_IDLE;
    else         state_q <= state_d;
  end

  // Allocator next state: one event walks IDLE -> DECIDE -> COMMIT; ready only in IDLE.
  always_comb begin
    state_d   = state_q;
    ready_out = 1'b0;
    case (state_q)
      ALLOC_IDLE: begin
        ready_out = 1'b1;
        if (valid_in) state_d = ALLOC_DECIDE;
      end
      ALLOC_DECIDE: state_d = ALLOC_COMMIT;
      ALLOC_COMMIT: state_d = ALLOC_IDLE;
      default:      state_d = ALLOC_IDLE;
    endcase
  end

  // Voice searches: key match, lowest free slot, oldest voice (ties to lowest index).
  always_comb begin
    match_vec  = '0;
    any_match  = 1'b0;
    any_free   = 1'b0;
    match_idx  = '0;
    free_idx   = '0;
    oldest_idx = '0;
    best_age   = age_q[0];
    for (int i = 0; i < NUM_VOICES; i++) begin
      match_vec[i] = on_q[i] && (rate_q[i] == ev_rate_q);
    end
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (match_vec[i]) begin
        any_match = 1'b1;
        match_idx = IDX_W'(i);
      end
      if (!on_q[i]) begin
        any_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (age_q[i] > best_age) begin
        best_age   = age_q[i];
        oldest_idx = IDX_W'(i);
      end
    end
  end

  // Capture the accepted event, then latch the chosen action while in DECIDE.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ev_on_q     <= 1'b0;
      ev_rate_q   <= '0;
      tgt_q       <= '0;
      steal_dec_q <= 1'b0;
      off_mask_q  <= '0;
    end else begin
      if (state_q == ALLOC_IDLE && valid_in) begin
        ev_on_q   <= is_note_on_in;
        ev_rate_q <= rate_in;
      end
      if (state_q == ALLOC_DECIDE) begin
        tgt_q       <= any_match ? match_idx : (any_free ? free_idx : oldest_idx);
        steal_dec_q <= ev_on_q && !any_match && !any_free;
        off_mask_q  <= match_vec;
      end
    end
  end

  // Commit the decision to the voice table and emit the one-cycle status pulses.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      on_q       <= '0;
      retrig_out <= '0;
      steal_out  <= 1'b0;
      drop_out   <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        rate_q[i] <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      retrig_out <= '0;
      steal_out  <= 1'b0;
      drop_out   <= valid_in && (state_q != ALLOC_IDLE);
      if (state_q == ALLOC_COMMIT) begin
        if (ev_on_q) begin
          steal_out <= steal_dec_q;
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (IDX_W'(i) == tgt_q) begin
              on_q[i]       <= 1'b1;
              rate_q[i]     <= ev_rate_q;
              age_q[i]      <= '0;
              retrig_out[i] <= 1'b1;
            end else if (on_q[i] && age_q[i] != AGE_MAX) begin
              age_q[i] <= age_q[i] + 1'b1;
            end
          end
        end else begin
          on_q <= on_q & ~off_mask_q;
        end
      end
    end
  end

  assign is_on_out = on_q;

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_rate_flat
    assign rate_out[g*RATE_WIDTH +: RATE_WIDTH] = rate_q[g];
  end

  voice_mix_accum #(
    .NUM_VOICES   (NUM_VOICES),
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .MIX_MODE     (MIX_MODE)
  ) u_mix (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .sample_tick_in   (sample_tick_in),
    .voice_on_in      (on_q),
    .samples_in       (samples_in),
    .stream_out       (stream_out),
    .stream_valid_out (stream_valid_out)
  );

endmodule

// File: tb/tb_poly_voice_mixer.sv
// tb/tb_poly_voice_mixer.sv - self-checking bench for poly_voice_mixer, average and saturating builds
module tb_poly_voice_mixer;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        valid_in;
  logic        is_note_on_in;
  logic [23:0] rate_in;
  logic        sample_tick_in;
  logic [63:0] samples_in;

  logic        ready0, ready1, steal0, steal1, drop0, drop1, sv0, sv1;
  logic [3:0]  is_on0, is_on1, retrig0, retrig1;
  logic [95:0] rate0, rate1;
  logic [15:0] stream0, stream1;

  int checks = 0;
  int errors = 0;

  bit m_on  [4];
  int m_rate[4];
  int m_age [4];

  always #5 clk_in = ~clk_in;

  poly_voice_mixer #(.NUM_VOICES(4), .SAMPLE_WIDTH(16), .RATE_WIDTH(24), .MIX_MODE(0)) dut0 (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .ready_out(ready0),
    .is_note_on_in(is_note_on_in), .rate_in(rate_in), .is_on_out(is_on0), .rate_out(rate0),
    .retrig_out(retrig0), .steal_out(steal0), .drop_out(drop0), .sample_tick_in(sample_tick_in),
    .samples_in(samples_in), .stream_out(stream0), .stream_valid_out(sv0));

  poly_voice_mixer #(.NUM_VOICES(4), .SAMPLE_WIDTH(16), .RATE_WIDTH(24), .MIX_MODE(1)) dut1 (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .ready_out(ready1),
    .is_note_on_in(is_note_on_in), .rate_in(rate_in), .is_on_out(is_on1), .rate_out(rate1),
    .retrig_out(retrig1), .steal_out(steal1), .drop_out(drop1), .sample_tick_in(sample_tick_in),
    .samples_in(samples_in), .stream_out(stream1), .stream_valid_out(sv1));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_on_vec();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_on[i];
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_on[i] = 0; m_rate[i] = 0; m_age[i] = 0;
    end
  endtask

  // Note rules: retrigger a sounding key, else first free voice, else steal the oldest.
  task automatic model_event(input bit on, input int rate, output logic [3:0] exp_retrig,
                             output bit exp_steal);
    int tgt;
    exp_retrig = '0;
    exp_steal  = 0;
    if (on) begin
      tgt = -1;
      for (int i = 0; i < 4; i++) if (tgt < 0 && m_on[i] && m_rate[i] == rate) tgt = i;
      for (int i = 0; i < 4; i++) if (tgt < 0 && !m_on[i]) tgt = i;
      if (tgt < 0) begin
        exp_steal = 1;
        tgt = 0;
        for (int i = 1; i < 4; i++) if (m_age[i] > m_age[tgt]) tgt = i;
      end
      for (int i = 0; i < 4; i++)
        if (i != tgt && m_on[i]) m_age[i] = (m_age[i] >= 3) ? 3 : m_age[i] + 1;
      m_on[tgt] = 1; m_rate[tgt] = rate; m_age[tgt] = 0;
      exp_retrig[tgt] = 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) if (m_on[i] && m_rate[i] == rate) m_on[i] = 0;
    end
  endtask

  task automatic check_voices(input string tag);
    check({tag, " is_on"}, is_on0, model_on_vec());
    check({tag, " is_on sat"}, is_on1, model_on_vec());
    for (int i = 0; i < 4; i++)
      check($sformatf("%s rate_out[%0d]", tag, i), rate0[i*24 +: 24], m_rate[i][23:0]);
  endtask

  task automatic send_event(input bit on, input int rate);
    logic [3:0] er;
    bit es;
    @(negedge clk_in);
    check("ready idle", ready0, 1);
    valid_in = 1; is_note_on_in = on; rate_in = rate[23:0];
    @(negedge clk_in);
    valid_in = 0;
    check("ready busy decide", ready0, 0);
    @(negedge clk_in);
    check("ready busy commit", ready0, 0);
    @(negedge clk_in);
    model_event(on, rate, er, es);
    check_voices($sformatf("event %0d/%0d", on, rate));
    check("retrig pulse", retrig0, er);
    check("steal pulse", steal0, es);
    check("no drop", drop0, 0);
    check("ready back", ready0, 1);
    @(negedge clk_in);
    check("retrig width", retrig0, 0);
    check("steal width", steal0, 0);
  endtask

  task automatic run_mix(input logic [63:0] smp, input bit hold_tick, input bit with_off,
                         input int off_rate);
    int sum;
    logic [15:0] e0, e1;
    logic [63:0] drive;
    logic [3:0] er;
    bit es;
    sum = 0;
    for (int k = 0; k < 4; k++) if (m_on[k]) sum += int'($signed(smp[k*16 +: 16]));
    e0 = 16'(sum >>> 2);
    if (sum > 32767) e1 = 16'h7fff;
    else if (sum < -32768) e1 = 16'h8000;
    else e1 = 16'(sum);
    @(negedge clk_in);
    sample_tick_in = 1;
    samples_in = {$urandom, $urandom};
    if (with_off) begin
      check("ready for off", ready0, 1);
      valid_in = 1; is_note_on_in = 0; rate_in = off_rate[23:0];
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_in);
      sample_tick_in = (k == 0) ? hold_tick : 1'b0;
      valid_in = 0;
      drive = {$urandom, $urandom};
      drive[k*16 +: 16] = smp[k*16 +: 16];
      samples_in = drive;
      check("valid quiet in accum", sv0, 0);
    end
    @(negedge clk_in);
    samples_in = {$urandom, $urandom};
    check("valid quiet T0+4", sv0, 0);
    @(negedge clk_in);
    check("valid T0+5 avg", sv0, 1);
    check("valid T0+5 sat", sv1, 1);
    check("stream avg", stream0, e0);
    check("stream sat", stream1, e1);
    @(negedge clk_in);
    check("valid width avg", sv0, 0);
    check("valid width sat", sv1, 0);
    check("stream hold", stream0, e0);
    if (with_off) begin
      model_event(0, off_rate, er, es);
      check_voices("off during accum");
    end
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 0; valid_in = 0; sample_tick_in = 0;
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1;
    model_clear();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int pool[7] = '{0, 1000, 2000, 3000, 4000, 5000, 6000};
    int drop_cnt, retrig_cnt;

    rst_in = 0; valid_in = 0; is_note_on_in = 0; rate_in = '0;
    sample_tick_in = 0; samples_in = '0;
    model_clear();
    @(negedge clk_in);
    check("reset ready", ready0, 1);
    check("reset is_on", is_on0, 0);
    check("reset stream", stream0, 0);
    check("reset valid", sv0, 0);
    @(negedge clk_in);
    rst_in = 1;
    run_mix({$urandom, $urandom}, 0, 0, 0);

    // Allocation, release and reuse of the lowest free voice.
    send_event(1, 1000); send_event(1, 2000); send_event(1, 3000);
    send_event(0, 2000);
    check("after off 2000", is_on0, 4'b0101);
    send_event(1, 4000);
    check("reuse voice 1", is_on0, 4'b0111);

    // Oldest-voice stealing.
    do_reset();
    send_event(1, 1000); send_event(1, 2000); send_event(1, 3000); send_event(1, 4000);
    send_event(1, 5000);
    check("steal v0 rate", rate0[23:0], 24'd5000);
    send_event(1, 6000);
    check("steal v1 rate", rate0[47:24], 24'd6000);

    // Retrigger and dropped events.
    do_reset();
    send_event(1, 1000); send_event(1, 1000);
    check("single voice", is_on0, 4'b0001);
    drop_cnt = 0; retrig_cnt = 0;
    @(negedge clk_in);
    valid_in = 1; is_note_on_in = 1; rate_in = 24'd1000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_in);
      drop_cnt += int'(drop0);
      retrig_cnt += int'(retrig0[0]);
      if (c == 2) valid_in = 0;
    end
    check("drop count", drop_cnt, 2);
    check("retrig count", retrig_cnt, 1);
    check("still one voice", is_on0, 4'b0001);

    // Mixing arithmetic.
    do_reset();
    send_event(1, 1000); send_event(1, 2000); send_event(1, 3000); send_event(1, 4000);
    run_mix(64'h4000_4000_4000_4000, 0, 0, 0);
    run_mix(64'h8000_8000_8000_8000, 1, 0, 0);

    // Asynchronous reset in the middle of an event and a mix.
    @(negedge clk_in);
    sample_tick_in = 1; valid_in = 1; is_note_on_in = 1; rate_in = 24'd7000;
    @(negedge clk_in);
    sample_tick_in = 0; valid_in = 0;
    #2 rst_in = 0;
    #1;
    check("midrst ready", ready0, 1);
    check("midrst is_on", is_on0, 0);
    check("midrst rate", {63'd0, |rate0}, 0);
    check("midrst retrig", retrig0, 0);
    check("midrst steal", steal0, 0);
    check("midrst drop", drop0, 0);
    check("midrst stream avg", stream0, 0);
    check("midrst stream sat", stream1, 0);
    check("midrst valid", sv0, 0);
    @(negedge clk_in);
    rst_in = 1;
    model_clear();
    run_mix({$urandom, $urandom}, 0, 0, 0);

    do_reset();
    send_event(1, 1000); send_event(1, 2000);
    run_mix(64'h7777_5555_f000_1000, 0, 0, 0);

    // Note-off committed while a mix is in flight.
    do_reset();
    send_event(1, 1000); send_event(1, 2000); send_event(1, 3000);
    run_mix(64'h0000_1200_0340_0056, 0, 1, 2000);
    check("off applied", is_on0, 4'b0101);
    run_mix(64'h0000_1200_0340_0056, 0, 0, 0);

    // Randomized events and mixes against the model.
    do_reset();
    for (int n = 0; n < 48; n++) begin
      send_event($urandom_range(0, 2) != 0, pool[$urandom_range(0, 6)]);
      if (n % 6 == 5)
        run_mix({$urandom, $urandom}, 1'($urandom_range(0, 1)), 0, 0);
      if (n % 12 == 11)
        run_mix({$urandom, $urandom}, 0, 1, pool[$urandom_range(0, 6)]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/poly_voice_mixer.md
# poly_voice_mixer

Polyphonic voice allocator and mixer sitting between `midi_processor` and the oscillator/`wave_loader` bank. It accepts note-on/note-off events, keyed by playback rate, and assigns them to `NUM_VOICES` oscillators. When the bank is full it steals the oldest voice. On each audio sample strobe it mixes the per-voice samples into one stream for `i2s_tx`.

## Interface
Parameters:
- `NUM_VOICES`, default 4: voice count; power of two, at least 2.
- `SAMPLE_WIDTH`, default 16: signed sample width.
- `RATE_WIDTH`, default 24: playback-rate (note key) width.
- `MIX_MODE`, default 0: 0 = average (arithmetic shift right by log2 N); 1 = saturating sum.

Ports:
- `clk_in`  in  1: system clock. One clock domain only.
- `rst_in`  in  1: reset, asynchronous, active-low.
- `valid_in`  in  1: note event strobe.
- `ready_out`  out  1: event accept ready.
- `is_note_on_in`  in  1: 1 = note-on, 0 = note-off.
- `rate_in`  in  `RATE_WIDTH`: note key (cycles between samples).
- `is_on_out`  out  `NUM_VOICES`: per-voice active flags.
- `rate_out`  out  `NUM_VOICES` x `RATE_WIDTH`: per-voice playback rate.
- `retrig_out`  out  `NUM_VOICES`: one-cycle pulse when a voice is (re)started.
- `steal_out`  out  1: one-cycle pulse when a voice is stolen.
- `drop_out`  out  1: one-cycle pulse when an event arrives while `ready_out` is 0.
- `sample_tick_in`  in  1: mix request strobe.
- `samples_in`  in  `NUM_VOICES` x `SAMPLE_WIDTH`: signed per-voice samples.
- `stream_out`  out  `SAMPLE_WIDTH`: mixed signed sample.
- `stream_valid_out`  out  1: one-cycle pulse when `stream_out` updates.

## Operation
- **Reset values.** While `rst_in` is 0:
  - all outputs are 0 except `ready_out`, which is 1;
  - all ages are 0;
  - both FSMs return to IDLE.
- **Allocator FSM** has three states: IDLE → DECIDE → COMMIT → IDLE.
  - IDLE: `ready_out` is 1. `valid_in` registers the event and moves to DECIDE.
  - DECIDE: registers the action and target voice.
  - COMMIT: updates `is_on_out`, `rate_out`, ages and pulses, then returns to IDLE.
- **Note-on**, in priority order:
  - If an active voice has a matching rate, it is retriggered: age set to 0, `retrig_out[i]` pulses, no duplicate voice is created.
  - Otherwise the lowest-index free voice is allocated.
  - Otherwise the oldest active voice (highest age, ties go to the lowest index) is replaced and `steal_out` pulses.
  - The target voice gets age 0, `rate_out[i]` = `rate_in`, `is_on_out[i]` = 1 and `retrig_out[i]` pulses.
  - Every other active voice's age increments, saturating at `NUM_VOICES`-1.
- **Note-off:**
  - Clears `is_on_out` for every active voice with a matching rate.
  - `rate_out` is retained and ages are unchanged.
  - If no voice matches, the event is consumed and nothing changes.
  - `rate_in` = 0 is a legal key.
- **Mixer FSM** has two states: IDLE and ACCUM.
  - In IDLE, `sample_tick_in` snapshots `is_on_out`, clears the accumulator and enters ACCUM.
  - ACCUM lasts `NUM_VOICES` cycles. In cycle k it adds the sign-extended `samples_in[k]` if snapshot bit k is 1.
  - The accumulator width is `SAMPLE_WIDTH` + log2 `NUM_VOICES`.
  - After the last add, `stream_out` is registered and `stream_valid_out` pulses.
  - MIX_MODE 0: `stream_out` = accumulator arithmetic-shifted right by log2 N.
  - MIX_MODE 1: `stream_out` = accumulator clamped to [-2^(S-1), 2^(S-1)-1], where S = `SAMPLE_WIDTH`.
  - `sample_tick_in` during ACCUM is ignored.
- **Concurrency:**
  - The allocator and mixer run independently.
  - An allocator commit during ACCUM does not affect the in-flight mix, because the mix uses the snapshot.
- **Reset mid-operation:** asynchronous clear. The partial mix is discarded and `stream_out` returns to 0.

## Timing
- **Event path.** Event accepted on edge E0:
  - outputs and pulses update on edge E2;
  - `ready_out` is 0 from after E0 until after E2;
  - the next event can be accepted on E3.
  - Minimum event spacing is 3 cycles.
- **Mix path.** Tick sampled on edge T0:
  - `samples_in[k]` is sampled on edge T0+1+k;
  - `stream_out` and `stream_valid_out` update on edge T0+N+1;
  - `stream_out` holds its value between updates.
- **Pulse outputs** are exactly one cycle wide.

## Structure
- `synth_pkg` (shared package) holds:
  - the `mix_mode_e` enum;
  - the `alloc_state_e` and `mix_state_e` typedefs;
  - the `sat_clamp` function;
  - a `VOICE_AGE_W` helper.
- Sub-module `voice_mix_accum`: the mixer FSM, accumulator and output scaling.
- Allocator logic (key match, free search, oldest search) stays in `poly_voice_mixer`.

## Test plan
All scenarios use N=4.
1. Reset low mid-activity → all outputs 0, `ready_out`=1. After release, a tick with all voices idle → `stream_out`=0 with `stream_valid_out` on T0+5.
2. Note-on 1000, 2000, 3000 → voices 0,1,2 active. Then note-off 2000 → `is_on_out`=4'b0101. Then note-on 4000 → voice 1, `is_on_out`=4'b0111.
3. Note-ons 1000, 2000, 3000, 4000, 5000 → the fifth steals voice 0: `rate_out[0]`=5000 and `steal_out` pulses once. Then note-on 6000 → steals voice 1.
4. Note-on 1000 twice → only voice 0 active; `retrig_out[0]` pulses twice; ages of other voices unaffected by the retrigger path. Valid strobe held high 3 cycles → `drop_out` pulses twice.
5. Mix:
   - all 4 voices active, samples 0x4000: MIX_MODE 0 → 0x4000; MIX_MODE 1 → 0x7FFF.
   - samples 0x8000 ×4: MIX_MODE 1 → 0x8000.
   - voices 0 and 1 only, samples 0x1000 and 0xF000 → 0x0000.
6. Note-off committed during ACCUM → the in-flight `stream_out` still includes that voice; the next tick excludes it.
